// File: rtl/approximate.sv
// Pipelined SFU polynomial datapath: result = c0 + c1*y + c2*y^2 (plus FMA and bypass), 3-cycle latency.
// Define APPROX_DEBUG_EN to expose the stage-aligned intermediate products on extra dbg_* outputs.
module approximate #(
    parameter int unsigned C0_WL  = 29,
    parameter int unsigned C0_FL  = 26,
    parameter int unsigned C1_WL  = 25,
    parameter int unsigned C1_FL  = 22,
    parameter int unsigned C2_WL  = 17,
    parameter int unsigned C2_FL  = 14,
    parameter int unsigned Y_WL   = 25,
    parameter int unsigned Y_FL   = 24,
    parameter int unsigned Y2_WL  = 30,
    parameter int unsigned Y2_FL  = 27,
    parameter int unsigned RES_FL = 46
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      precision,
    input  logic                      skip,
    input  logic [3:0]                opcode,
    input  logic signed [C0_WL-1:0]   c0,
    input  logic signed [C1_WL-1:0]   c1,
    input  logic signed [C2_WL-1:0]   c2,
    input  logic signed [Y_WL-1:0]    y,
    input  logic [8:0]                exponent_diff,
`ifdef APPROX_DEBUG_EN
    output logic signed [C1_WL+Y_WL-1:0] dbg_c1y,
    output logic signed [Y2_WL-1:0]      dbg_y2,
    output logic signed [RES_FL+2:0]     dbg_c2y,
    output logic signed [RES_FL+2:0]     dbg_c0_temp,
    output logic signed [RES_FL+2:0]     dbg_c1y_temp,
    output logic signed [RES_FL+2:0]     dbg_c2y_temp,
`endif
    output logic                      out_valid,
    output logic signed [RES_FL+3:0]  result
);

    localparam int unsigned PW     = RES_FL + 3;
    localparam int unsigned RW     = RES_FL + 4;
    localparam int unsigned C1Y_W  = C1_WL + Y_WL;
    localparam int unsigned YY_W   = 2 * Y_WL;
    localparam int unsigned C2Y_W  = C2_WL + Y2_WL;
    localparam int unsigned C0_SH  = RES_FL - C0_FL;
    localparam int unsigned Y2_SH  = 2 * Y_FL - Y2_FL;
    localparam int unsigned C2Y_SH = RES_FL - (C2_FL + Y2_FL);

    // Stage 1 combinational
    logic signed [C1Y_W-1:0] w_c1y;
    logic signed [YY_W-1:0]  w_yy;
    logic signed [Y2_WL-1:0] w_y2;
    logic signed [PW-1:0]    w_c0_ext;
    logic signed [PW-1:0]    w_c0_temp;
    logic [8:0]              w_shamt;
    logic                    w_fma;

    assign w_fma    = (opcode == 4'b0000);
    assign w_c1y    = C1Y_W'(c1) * C1Y_W'(y);
    assign w_yy     = YY_W'(y) * YY_W'(y);
    assign w_y2     = Y2_WL'(w_yy >>> Y2_SH);
    assign w_c0_ext = PW'(c0) <<< C0_SH;
    // Clamp so every oversized alignment collapses to pure sign fill
    assign w_shamt  = (exponent_diff > 9'(PW - 1)) ? 9'(PW - 1) : exponent_diff;
    assign w_c0_temp = (w_fma && !skip) ? (w_c0_ext >>> w_shamt) : w_c0_ext;

    logic                    r1_valid, r1_skip, r1_fma, r1_prec;
    logic signed [C1Y_W-1:0] r_c1y;
    logic signed [Y2_WL-1:0] r_y2;
    logic signed [PW-1:0]    r_c0_temp;
    logic signed [C2_WL-1:0] r_c2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid  <= 1'b0;
            r1_skip   <= 1'b0;
            r1_fma    <= 1'b0;
            r1_prec   <= 1'b0;
            r_c1y     <= '0;
            r_y2      <= '0;
            r_c0_temp <= '0;
            r_c2      <= '0;
        end else begin
            r1_valid  <= in_valid;
            r1_skip   <= skip;
            r1_fma    <= w_fma;
            r1_prec   <= precision;
            r_c1y     <= w_c1y;
            r_y2      <= w_y2;
            r_c0_temp <= w_c0_temp;
            r_c2      <= c2;
        end
    end

    // Stage 2 combinational: c2*y2 realigned to the result fraction
    logic signed [C2Y_W-1:0] w_c2y_prod;
    logic signed [PW-1:0]    w_c2y;
    logic signed [PW-1:0]    w_c2y_temp;
    logic signed [PW-1:0]    w_c1y_temp;

    assign w_c2y_prod = C2Y_W'(r_c2) * C2Y_W'(r_y2);
    assign w_c2y      = PW'(w_c2y_prod) <<< C2Y_SH;
    assign w_c2y_temp = (r1_skip || r1_fma || r1_prec) ? '0 : w_c2y;
    assign w_c1y_temp = r1_skip ? '0 : PW'(r_c1y);

    logic                 r2_valid;
    logic signed [PW-1:0] r2_c0_temp;
    logic signed [PW-1:0] r_c1y_temp;
    logic signed [PW-1:0] r_c2y_temp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r2_valid   <= 1'b0;
            r2_c0_temp <= '0;
            r_c1y_temp <= '0;
            r_c2y_temp <= '0;
        end else begin
            r2_valid   <= r1_valid;
            r2_c0_temp <= r_c0_temp;
            r_c1y_temp <= w_c1y_temp;
            r_c2y_temp <= w_c2y_temp;
        end
    end

    // Stage 3: wrapping three-term sum
    logic signed [RW-1:0] w_sum;
    assign w_sum = RW'(r2_c0_temp) + RW'(r_c1y_temp) + RW'(r_c2y_temp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
        end else begin
            out_valid <= r2_valid;
            result    <= w_sum;
        end
    end

`ifdef APPROX_DEBUG_EN
    logic signed [PW-1:0] r_c2y_dbg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c2y_dbg <= '0;
        end else begin
            r_c2y_dbg <= w_c2y;
        end
    end

    assign dbg_c1y      = r_c1y;
    assign dbg_y2       = r_y2;
    assign dbg_c2y      = r_c2y_dbg;
    assign dbg_c0_temp  = r_c0_temp;
    assign dbg_c1y_temp = r_c1y_temp;
    assign dbg_c2y_temp = r_c2y_temp;
`endif

endmodule

// File: tb/tb_approximate.sv
// Bench for approximate: directed vector table, randomized stream vs. arithmetic model, mid-stream reset.
module tb_approximate;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               precision;
    logic               skip;
    logic [3:0]         opcode;
    logic signed [28:0] c0;
    logic signed [24:0] c1;
    logic signed [16:0] c2;
    logic signed [24:0] y;
    logic [8:0]         exponent_diff;
    logic               out_valid;
    logic signed [49:0] result;
`ifdef APPROX_DEBUG_EN
    logic signed [49:0] dbg_c1y;
    logic signed [29:0] dbg_y2;
    logic signed [48:0] dbg_c2y, dbg_c0_temp, dbg_c1y_temp, dbg_c2y_temp;
`endif

    approximate dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .precision(precision),
        .skip(skip), .opcode(opcode), .c0(c0), .c1(c1), .c2(c2), .y(y),
        .exponent_diff(exponent_diff),
`ifdef APPROX_DEBUG_EN
        .dbg_c1y(dbg_c1y), .dbg_y2(dbg_y2), .dbg_c2y(dbg_c2y),
        .dbg_c0_temp(dbg_c0_temp), .dbg_c1y_temp(dbg_c1y_temp), .dbg_c2y_temp(dbg_c2y_temp),
`endif
        .out_valid(out_valid), .result(result)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrap(input longint x, input int n);
        return (x <<< (64 - n)) >>> (64 - n);
    endfunction

    // Arithmetic reference: all quantities as integers scaled by their fraction bits
    function automatic longint model(input longint a0, input longint a1, input longint a2,
                                     input longint ay, input int ed, input bit fma,
                                     input bit prec, input bit skp);
        longint v0, v1, yy2, v2;
        v0 = a0 * 64'sd1048576;
        if (fma && !skp) v0 = v0 >>> ((ed > 63) ? 63 : ed);
        v1  = skp ? 64'sd0 : wrap(a1 * ay, 49);
        yy2 = (ay * ay) >>> 21;
        v2  = (skp || fma || prec) ? 64'sd0 : wrap(a2 * yy2 * 64'sd32, 49);
        return wrap(v0 + v1 + v2, 50);
    endfunction

    typedef struct {
        string  name;
        bit     fma, prec, skp;
        longint a0, a1, a2, ay;
        int     ed;
        real    exp;
    } vec_t;

    task automatic drive(input bit v, input bit fma, input bit prec, input bit skp,
                         input longint a0, input longint a1, input longint a2,
                         input longint ay, input int ed);
        in_valid      = v;
        opcode        = fma ? 4'b0000 : 4'(1 + $urandom_range(0, 14));
        precision     = prec;
        skip          = skp;
        c0            = 29'(a0);
        c1            = 25'(a1);
        c2            = 17'(a2);
        y             = 25'(ay);
        exponent_diff = 9'(ed);
    endtask

    vec_t   vecs[7];
    bit     hv[400];
    longint hr[400];

    initial begin
        logic signed [28:0] fc0;
        logic signed [24:0] fc1;
        longint one46;
        fc0   = 29'b11000000101010000000000000000;
        fc1   = 25'b1001000111010000000000000;
        one46 = 64'sd1 <<< 46;

        vecs[0] = '{"fma_basic", 1, 0, 0, longint'(fc0), longint'(fc1), 0, 64'sd5 <<< 21, 0, -4.131591796875};
        vecs[1] = '{"fma_negated", 1, 0, 0, -longint'(fc0), -longint'(fc1), 0, 64'sd5 <<< 21, 0, 4.131591796875};
        vecs[2] = '{"poly_full", 0, 0, 0, 0, 0, 64'sd1 <<< 14, 64'sd1 <<< 23, 0, 0.25};
        vecs[3] = '{"poly_reduced", 0, 1, 0, 0, 0, 64'sd1 <<< 14, 64'sd1 <<< 23, 0, 0.0};
        vecs[4] = '{"bypass", 0, 0, 1, 64'sd3 <<< 25, 64'sd1 <<< 22, 64'sd1 <<< 14, 64'sd1 <<< 23, 0, 1.5};
        vecs[5] = '{"fma_shift1", 1, 0, 0, -(64'sd2 <<< 26), 0, 0, 64'sd1 <<< 23, 1, -1.0};
        vecs[6] = '{"fma_shift300", 1, 0, 0, -(64'sd2 <<< 26), 0, 0, 64'sd1 <<< 23, 300, -1.0 / real'(one46)};

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_valid", longint'(out_valid), 0);
        chk("reset_result", longint'(result), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: one at a time, checked exactly three edges later
        for (int i = 0; i < 7; i++) begin
            drive(1, vecs[i].fma, vecs[i].prec, vecs[i].skp, vecs[i].a0, vecs[i].a1,
                  vecs[i].a2, vecs[i].ay, vecs[i].ed);
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            chk({vecs[i].name, "_early"}, longint'(out_valid), 0);
            @(negedge clk);
            chk({vecs[i].name, "_valid"}, longint'(out_valid), 1);
            chk(vecs[i].name, longint'(result), longint'(vecs[i].exp * real'(one46)));
            @(negedge clk);
            chk({vecs[i].name, "_pulse"}, longint'(out_valid), 0);
        end

        // Randomized back-to-back stream against the model
        for (int k = 0; k < 300; k++) begin
            bit v, f, p, s;
            longint a0, a1, a2, ay;
            int ed;
            if (k >= 3) begin
                chk("rand_valid", longint'(out_valid), longint'(hv[k-3]));
                if (hv[k-3]) chk("rand_result", longint'(result), hr[k-3]);
            end
            v  = (k >= 297) ? 1'b1 : ($urandom_range(0, 3) != 0);
            f  = $urandom_range(0, 2) == 0;
            p  = $urandom_range(0, 1) == 1;
            s  = $urandom_range(0, 5) == 0;
            a0 = longint'($signed(29'($urandom)));
            a1 = longint'($signed(25'($urandom)));
            a2 = longint'($signed(17'($urandom)));
            ay = longint'($signed(25'($urandom)));
            ed = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 50));
            drive(v, f, p, s, a0, a1, a2, ay, ed);
            hv[k] = v;
            hr[k] = model(a0, a1, a2, ay, ed, f, p, s);
            @(negedge clk);
        end

        // Mid-stream asynchronous reset with data in flight
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", longint'(out_valid), 0);
        chk("midrst_result", longint'(result), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_valid", longint'(out_valid), 0);
        end

        // Recovery: a fresh transaction still flows correctly
        drive(1, 1, 0, 0, vecs[0].a0, vecs[0].a1, 0, vecs[0].ay, 0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("recover_valid", longint'(out_valid), 1);
        chk("recover_result", longint'(result), model(vecs[0].a0, vecs[0].a1, 0, vecs[0].ay, 0, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/approximate.md
Name: approximate

Overview:
- Pipelined second-order polynomial approximation datapath for the special-function unit (SFU).
- Computes `result = c0 + c1*y + c2*y²` in signed fixed point.
- Also supports an FMA mode (`c0 + c1*y` with `c0` alignment by `exponent_diff`) and a bypass.
- Sits after the coefficient lookup table and before the final rounding/normalisation stage.

Parameters:
- C0_WL, 29, c0 word length (signed; integer bits include sign).
- C0_FL, 26, c0 fraction bits.
- C1_WL, 25, c1 word length.
- C1_FL, 22, c1 fraction bits.
- C2_WL, 17, c2 word length.
- C2_FL, 14, c2 fraction bits.
- Y_WL, 25, y word length.
- Y_FL, 24, y fraction bits.
- Y2_WL, 30, truncated y² word length.
- Y2_FL, 27, truncated y² fraction bits.
- RES_FL, 46, result fraction bits (result width = RES_FL+4 = 50).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  input operands valid this cycle.
- precision  in  1  0 = full second order; 1 = reduced (c2 term dropped).
- skip  in  1  1 = bypass; result = aligned c0.
- opcode  in  4  4'b0000 = FMA; any other value = POLY.
- c0  in  C0_WL  signed coefficient.
- c1  in  C1_WL  signed coefficient.
- c2  in  C2_WL  signed coefficient.
- y  in  Y_WL  signed reduced argument.
- exponent_diff  in  9  unsigned right-shift of c0, used in FMA only.
- out_valid  out  1  result valid.
- result  out  50  signed, 4 integer bits (incl. sign) . 46 fraction bits.

Behaviour:
- Reset (async, rst_n=0): all pipeline registers, out_valid and result go to 0 immediately. Assertion mid-operation discards in-flight data.
- Fully pipelined: throughput 1 per cycle, latency exactly 3 cycles from in_valid to out_valid. No backpressure.
- Stall-free valid pipe: data registers load every cycle; out_valid is in_valid delayed by 3.
- Stage 1:
  - c1y = c1*y, exact product, 50 bits with FL = C1_FL+Y_FL = 46.
  - y2 = y*y truncated (toward −inf) to Y2_WL/Y2_FL.
  - c0_temp = c0 sign-extended to 49 bits, FL 46.
  - In FMA mode, c0_temp is arithmetic-right-shifted by exponent_diff. Shifts ≥ 49 yield all sign bits.
- Stage 2:
  - c2y = c2*y2 (FL 41), shifted left 5 to FL 46, sign-extended/truncated to 49 bits.
  - c2y = 0 when precision=1, opcode=FMA, or skip=1.
  - c1y = 0 when skip=1.
- Stage 3: result = c0_temp + c1y + c2y, 50-bit two's-complement, wraps modulo 2^50, no saturation.
- Opcode/precision/skip/exponent_diff travel with their data through the pipe. Mixed modes back-to-back are legal.
- Priority: skip > opcode > precision.

Optional Feature:
- APPROX_DEBUG_EN defined: extra outputs expose the stage-aligned intermediates, each registered with the stage that computes it:
  - c1y (50)
  - y2 (30)
  - c2y (49)
  - c0_temp (49)
  - c1y_temp (49)
  - c2y_temp (49)
- Undefined: these ports do not exist; core behaviour is identical.

Test Plan:
- FMA: opcode=0000, precision=0, skip=0, c0=29'b11000000101010000000000000000 (−1.9794921875), c1=25'b1001000111010000000000000 (−3.443359375), c2=0, y=25'b0101000000000000000000000 (0.625), exponent_diff=0.
  - Three cycles later, out_valid=1 and result = −4.131591796875 (×2^46, 50-bit two's complement).
  - Negated result = +4.131591796875.
- POLY, precision=0: c0=0, c1=0, c2=1.0, y=0.5 -> result = 0.25. With precision=1 -> result = 0.
- skip=1, c0=1.5, c1=c2=1.0, y=0.5 -> result = 1.5.
- FMA shift: c0=−2.0, exponent_diff=1, c1=0 -> −1.0; exponent_diff=300 -> all-ones (−2^-46).
- Back-to-back inputs on consecutive cycles -> consecutive out_valid pulses with correct results. rst_n pulse mid-stream -> outputs 0 immediately, no stale valid after release.
